alu_resp: RTL and testbench



---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu.sv | 55 +++++
 rtl/alu_resp.sv | 90 +++++++++
 tb/tb_alu_resp.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU responder: operation codes, flag struct and buffered response entry.
package alu_pkg;

   localparam int WIDTH = 64;

   localparam logic [2:0] ALU_PASS_B   = 3'b000;
   localparam logic [2:0] ALU_ADD      = 3'b010;
   localparam logic [2:0] ALU_SUBTRACT = 3'b011;
   localparam logic [2:0] ALU_AND      = 3'b100;
   localparam logic [2:0] ALU_OR       = 3'b101;
   localparam logic [2:0] ALU_XOR      = 3'b110;

   typedef struct packed {
      logic n;
      logic z;
      logic v;
      logic c;
   } alu_flags_t;

   typedef struct packed {
      logic [WIDTH-1:0] result;
      alu_flags_t       flags;
      logic             err;
   } rsp_entry_t;

endpackage

// File: rtl/alu.sv
// Combinational 64-bit ALU. With ALU_RESP_ILLEGAL_TRAP_EN defined, codes 001/111 trap
// (result 0, err 1, flags 0); otherwise they behave as PASS_B.
module alu
   import alu_pkg::*;
(
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       cntrl_i,
   output logic [WIDTH-1:0] result_o,
   output alu_flags_t       flags_o,
   output logic             err_o
);

   logic             sub;
   logic             arith;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;

   // Subtract shares the adder: A + ~B + 1, so carry-out means "no borrow".
   assign sub   = (cntrl_i == ALU_SUBTRACT);
   assign b_eff = sub ? ~b_i : b_i;
   assign sum   = {1'b0, a_i} + {1'b0, b_eff} + (WIDTH+1)'(sub);

   always_comb begin
      result_o = b_i;
      flags_o  = '0;
      err_o    = 1'b0;
      arith    = 1'b0;
      case (cntrl_i)
         ALU_ADD, ALU_SUBTRACT: begin
            result_o = sum[WIDTH-1:0];
            arith    = 1'b1;
         end
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         ALU_XOR: result_o = a_i ^ b_i;
`ifdef ALU_RESP_ILLEGAL_TRAP_EN
         3'b001, 3'b111: begin
            result_o = '0;
            err_o    = 1'b1;
         end
`endif
         default: result_o = b_i;
      endcase

      flags_o.n = result_o[WIDTH-1];
      flags_o.z = (result_o == '0);
      if (arith) begin
         flags_o.v = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
         flags_o.c = sum[WIDTH];
      end
      if (err_o) flags_o = '0;
   end

endmodule

// File: rtl/alu_resp.sv
// Handshaked ALU responder: 2-entry response FIFO plus architectural NZVC flag register.
// Optional illegal-op trapping via ALU_RESP_ILLEGAL_TRAP_EN (implemented in alu).
module alu_resp
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [2:0]       req_cntrl,
   input  logic             req_setflags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_negative,
   output logic             rsp_zero,
   output logic             rsp_overflow,
   output logic             rsp_carry_out,
   output logic             rsp_err,
   output logic [3:0]       flags_q
);

   logic [WIDTH-1:0] alu_result;
   alu_flags_t       alu_flags;
   logic             alu_err;

   alu u_alu (
      .a_i      (req_a),
      .b_i      (req_b),
      .cntrl_i  (req_cntrl),
      .result_o (alu_result),
      .flags_o  (alu_flags),
      .err_o    (alu_err)
   );

   rsp_entry_t mem_q [2];
   rsp_entry_t head;
   logic       rd_ptr_q, wr_ptr_q;
   logic [1:0] count_q, count_d;
   logic [3:0] flags_d;
   logic       push, pop;

   // Ready depends only on the registered count, never on rsp_ready.
   assign req_ready = (count_q != 2'd2);
   assign rsp_valid = (count_q != 2'd0);
   assign push      = req_valid && req_ready;
   assign pop       = rsp_valid && rsp_ready;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      flags_d = flags_q;
      if (push && req_setflags && !alu_err) flags_d = alu_flags;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q  <= 2'd0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         flags_q  <= 4'd0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         count_q <= count_d;
         flags_q <= flags_d;
         if (push) begin
            mem_q[wr_ptr_q] <= '{result: alu_result, flags: alu_flags, err: alu_err};
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
   end

   // Stale storage is masked so the response bus reads zero while empty.
   assign head          = rsp_valid ? mem_q[rd_ptr_q] : '0;
   assign rsp_result    = head.result;
   assign rsp_negative  = head.flags.n;
   assign rsp_zero      = head.flags.z;
   assign rsp_overflow  = head.flags.v;
   assign rsp_carry_out = head.flags.c;
   assign rsp_err       = head.err;

endmodule

// File: tb/tb_alu_resp.sv
// Self-checking bench for alu_resp: directed test-plan steps plus randomized traffic against a queue model.
module tb_alu_resp;
   import alu_pkg::*;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             req_valid, req_ready, req_setflags;
   logic [63:0]      req_a, req_b;
   logic [2:0]       req_cntrl;
   logic             rsp_valid, rsp_ready;
   logic [63:0]      rsp_result;
   logic             rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out, rsp_err;
   logic [3:0]       flags_q;

   always #5 clk = ~clk;

   alu_resp dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_cntrl(req_cntrl), .req_setflags(req_setflags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_negative(rsp_negative), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
      .rsp_carry_out(rsp_carry_out), .rsp_err(rsp_err), .flags_q(flags_q)
   );

   int          errors = 0;
   int          checks = 0;
   logic [68:0] model_q [$];   // {err, n, z, v, c, result[63:0]}
   logic [3:0]  mflags;
   logic        acc_last;

`ifdef ALU_RESP_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   // Reference: plain integer arithmetic, signed overflow judged by widening.
   function automatic logic [68:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] op);
      logic [63:0]        res;
      logic               v, c, err;
      logic [64:0]        us;
      logic signed [65:0] ss, rs;
      res = b; v = 0; c = 0; err = 0;
      case (op)
         3'd2: begin
            us  = {1'b0, a} + {1'b0, b};
            res = us[63:0]; c = us[64];
            ss  = $signed(a) + $signed(b);
            rs  = $signed(res);
            v   = (ss != rs);
         end
         3'd3: begin
            res = a - b; c = (a >= b);
            ss  = $signed(a) - $signed(b);
            rs  = $signed(res);
            v   = (ss != rs);
         end
         3'd4: res = a & b;
         3'd5: res = a | b;
         3'd6: res = a ^ b;
         3'd1, 3'd7: if (TRAP) begin res = 0; err = 1; end
         default: res = b;
      endcase
      if (err) return {1'b1, 4'b0000, 64'd0};
      return {1'b0, res[63], (res == 64'd0), v, c, res};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs at negedge against the model, then advance the model at posedge.
   task automatic cycle();
      logic        pop, acc;
      logic [68:0] hd, e;
      @(negedge clk);
      chk("req_ready", {63'd0, req_ready}, {63'd0, model_q.size() < 2});
      chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, model_q.size() != 0});
      if (model_q.size() != 0) begin
         hd = model_q[0];
         chk("rsp_result", rsp_result, hd[63:0]);
         chk("rsp_nzvc", {60'd0, rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out},
             {60'd0, hd[67:64]});
         chk("rsp_err", {63'd0, rsp_err}, {63'd0, hd[68]});
      end else begin
         chk("rsp_result_empty", rsp_result, 64'd0);
      end
      chk("flags_q", {60'd0, flags_q}, {60'd0, mflags});
      acc = req_valid && (model_q.size() < 2);
      pop = (model_q.size() != 0) && rsp_ready;
      @(posedge clk);
      if (pop) void'(model_q.pop_front());
      if (acc) begin
         e = ref_op(req_a, req_b, req_cntrl);
         model_q.push_back(e);
         if (req_setflags && !e[68]) mflags = e[67:64];
      end
      acc_last = acc;
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic sf);
      req_valid = v; req_cntrl = op; req_a = a; req_b = b; req_setflags = sf;
   endtask

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 5))
         0: return 64'd0;
         1: return 64'hFFFF_FFFF_FFFF_FFFF;
         2: return 64'h7FFF_FFFF_FFFF_FFFF;
         3: return 64'h8000_0000_0000_0000;
         4: return 64'($urandom_range(0, 3));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      int accepts, budget;
      logic pending;
      mflags = 4'd0; acc_last = 1'b0;
      reset_n = 1'b0; rsp_ready = 1'b1;
      drive(0, 3'd0, 64'd0, 64'd0, 0);
      #12;
      chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
      chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("reset_flags", {60'd0, flags_q}, 64'd0);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;

      // ADD with carry-out and setflags
      drive(1, ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFD, 64'hB, 1);
      cycle();
      drive(0, 3'd0, 64'd0, 64'd0, 0);
      chk("add1_result", rsp_result, 64'h8);
      chk("add1_nzvc", {60'd0, rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out}, 64'b0001);
      chk("add1_flags_q", {60'd0, flags_q}, 64'b0001);
      cycle();

      drive(1, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
      cycle();
      drive(0, 3'd0, 64'd0, 64'd0, 0);
      chk("add2_result", rsp_result, 64'h8000_0000_0000_0000);
      chk("add2_nzvc", {60'd0, rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out}, 64'b1010);
      cycle();

      drive(1, ALU_SUBTRACT, 64'd5, 64'd5, 0);
      cycle();
      drive(0, 3'd0, 64'd0, 64'd0, 0);
      chk("sub_result", rsp_result, 64'd0);
      chk("sub_nzvc", {60'd0, rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out}, 64'b0101);
      chk("sub_flags_q_held", {60'd0, flags_q}, 64'b0001);
      cycle();

      // Backpressure: three XORs with the consumer stalled
      rsp_ready = 1'b0;
      accepts = 0;
      for (int i = 0; i < 3; i++) begin
         drive(1, ALU_XOR, {$urandom, $urandom}, {$urandom, $urandom}, 0);
         budget = 0;
         do begin
            if (accepts == 2 && budget == 2) begin
               chk("bp_req_ready_low", {63'd0, req_ready}, 64'd0);
               rsp_ready = 1'b1;
            end
            cycle();
            budget++;
         end while (!acc_last && budget < 10);
         if (!acc_last) chk("bp_accept_timeout", 64'd0, 64'd1);
         accepts++;
      end
      drive(0, 3'd0, 64'd0, 64'd0, 0);
      budget = 0;
      while (model_q.size() != 0 && budget < 10) begin cycle(); budget++; end
      chk("bp_drained", {63'd0, rsp_valid}, 64'd0);

      // Illegal op code 111
      drive(1, 3'b111, 64'd3, 64'h55, 1);
      cycle();
      drive(0, 3'd0, 64'd0, 64'd0, 0);
      chk("illegal_result", rsp_result, TRAP ? 64'd0 : 64'h55);
      chk("illegal_err", {63'd0, rsp_err}, {63'd0, TRAP});
      chk("illegal_flags_q", {60'd0, flags_q}, TRAP ? 64'b0001 : 64'b0000);
      cycle();

      // Randomized traffic with random consumer stalls; requests held until accepted
      pending = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!pending) begin
            if ($urandom_range(0, 3) != 0) begin
               drive(1, 3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
               pending = 1'b1;
            end else begin
               req_valid = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 2) != 0);
         cycle();
         if (acc_last) pending = 1'b0;
      end
      while (pending) begin cycle(); if (acc_last) pending = 1'b0; end
      drive(0, 3'd0, 64'd0, 64'd0, 0);

      // Asynchronous reset with two entries buffered and nonzero flags
      rsp_ready = 1'b1;
      cycle(); cycle();
      rsp_ready = 1'b0;
      drive(1, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1);
      cycle();
      drive(1, ALU_OR, 64'hF0, 64'h0F, 0);
      cycle();
      drive(0, 3'd0, 64'd0, 64'd0, 0);
      cycle();
      chk("pre_reset_full", {62'd0, model_q.size() == 2, rsp_valid}, 64'd3);
      @(negedge clk); #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("async_rst_req_ready", {63'd0, req_ready}, 64'd1);
      chk("async_rst_flags", {60'd0, flags_q}, 64'd0);
      chk("async_rst_result", rsp_result, 64'd0);
      model_q.delete();
      mflags = 4'd0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      rsp_ready = 1'b1;
      drive(1, ALU_AND, 64'hFF00, 64'h0FF0, 1);
      cycle();
      drive(0, 3'd0, 64'd0, 64'd0, 0);
      cycle(); cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
